// File: rtl/fp_normalize_round.sv
// fp_normalize_round: normalizes a 29-bit extended mantissa one bit per cycle,
// rounds to nearest-even on the guard/round/sticky bits, and packs an IEEE-754
// single-precision word, flagging overflow (to infinity) and underflow (to zero).
// Latency from the sampling edge to done: 3+k (k shifts), 2 for zero, 2+k on shift underflow.
// Backpressure: start is sampled only in IDLE; done is held until start drops.
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_start              level request, sampled in IDLE only
//   i_mant_in[28:0]      [28:27] headroom, [26] hidden one, [25:3] fraction, [2:0] G/R/S
//   i_exp_in[7:0]        biased exponent of bit 26
//   i_sign_in            result sign
//   o_result[31:0]       packed {sign, exp, frac}
//   o_done               result valid
//   o_overflow           saturated to infinity
//   o_underflow          nonzero value flushed to signed zero
module fp_normalize_round #(
  parameter int EXP_W = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [28:0] i_mant_in,
  input  logic [7:0]  i_exp_in,
  input  logic        i_sign_in,
  output logic [31:0] o_result,
  output logic        o_done,
  output logic        o_overflow,
  output logic        o_underflow
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CHECK   = 3'd1;
  localparam logic [2:0] SHIFT_R = 3'd2;
  localparam logic [2:0] SHIFT_L = 3'd3;
  localparam logic [2:0] ROUND   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(255);

  logic [2:0]              r_state;
  logic [28:0]             r_mant;
  logic signed [EXP_W-1:0] r_exp;
  logic                    r_sign;

  logic [28:0]             w_mant_r;
  logic [28:0]             w_mant_l;
  logic signed [EXP_W-1:0] w_exp_inc;
  logic signed [EXP_W-1:0] w_exp_dec;
  logic                    w_inc;
  logic [24:0]             w_m25;
  logic signed [EXP_W-1:0] w_exp_rnd;
  logic [22:0]             w_frac;
  logic                    w_unused_hidden;

  // Right shift folds the bit falling off the bottom into the sticky position.
  assign w_mant_r  = {1'b0, r_mant[28:2], r_mant[1] | r_mant[0]};
  assign w_mant_l  = {r_mant[27:0], 1'b0};
  assign w_exp_inc = r_exp + EXP_ONE;
  assign w_exp_dec = r_exp - EXP_ONE;

  // Round to nearest-even: up when above halfway, or exactly halfway with odd LSB.
  assign w_inc     = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
  assign w_m25     = {1'b0, r_mant[26:3]} + {24'd0, w_inc};
  // A carry out of the significand means it became exactly 2.0: fraction is zero.
  assign w_exp_rnd = w_m25[24] ? w_exp_inc : r_exp;
  assign w_frac    = w_m25[24] ? 23'd0 : w_m25[22:0];
  // The hidden one is implied in the packed format.
  assign w_unused_hidden = w_m25[23];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_mant      <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      o_result    <= '0;
      o_done      <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_mant      <= i_mant_in;
            r_exp       <= {{(EXP_W-8){1'b0}}, i_exp_in};
            r_sign      <= i_sign_in;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            r_state     <= CHECK;
          end
        end
        CHECK: begin
          if (r_mant == 29'd0) begin
            o_result <= {r_sign, 31'd0};
            o_done   <= 1'b1;
            r_state  <= DONE;
          end else if (r_mant[28:27] != 2'b00) begin
            r_state <= SHIFT_R;
          end else if (!r_mant[26]) begin
            r_state <= SHIFT_L;
          end else begin
            r_state <= ROUND;
          end
        end
        SHIFT_R: begin
          r_mant <= w_mant_r;
          r_exp  <= w_exp_inc;
          // Post-shift headroom is clear once the old top bit was zero.
          if (!r_mant[28]) r_state <= ROUND;
        end
        SHIFT_L: begin
          r_mant <= w_mant_l;
          r_exp  <= w_exp_dec;
          // Exponent exhaustion wins over reaching the hidden-one position.
          if (w_exp_dec <= EXP_ZERO) begin
            o_underflow <= 1'b1;
            o_result    <= {r_sign, 31'd0};
            o_done      <= 1'b1;
            r_state     <= DONE;
          end else if (r_mant[25]) begin
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_exp <= w_exp_rnd;
          if (w_exp_rnd >= EXP_MAX) begin
            o_overflow <= 1'b1;
            o_result   <= {r_sign, 8'hFF, 23'd0};
          end else if (w_exp_rnd <= EXP_ZERO) begin
            o_underflow <= 1'b1;
            o_result    <= {r_sign, 31'd0};
          end else begin
            o_result <= {r_sign, w_exp_rnd[7:0], w_frac};
          end
          o_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          if (!i_start) begin
            o_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
